// File: rtl/cabac_ctx_ram_ctrl_if.sv
// Engine-side request/response bundle for the CABAC context RAM controller.
// The entropy engine drives the master side, the controller the slave side.
interface cabac_ctx_ram_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              wr_req_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              rd_ack_o;
  logic              wr_ack_o;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;

  modport master (
    output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
    input  rd_ack_o, wr_ack_o, rd_valid_o, rd_data_o
  );

  modport slave (
    input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
    output rd_ack_o, wr_ack_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/cabac_ctx_ram_ctrl.sv
// CABAC context RAM controller: loads the context table from an init ROM
// into a single-port RAM, then arbitrates engine reads and write-backs
// (write wins over read, table load wins over both).
module cabac_ctx_ram_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_start_i,
  output logic [ADDR_W-1:0] init_addr_o,
  input  logic [DATA_W-1:0] init_data_i,
  output logic              init_busy_o,
  output logic              init_done_o,
  output logic              ctx_valid_o,
  cabac_ctx_ram_ctrl_if.slave eng,
  output logic              ram_cen_o,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  typedef enum logic {IDLE, INIT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic              last_entry;
  logic              rd_ack, wr_ack;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_hold_q;

  assign last_entry = (cnt_q == ADDR_W'(DEPTH - 1));

  // Next state, request arbitration and RAM port drive; reset blocks all access.
  always_comb begin
    state_d     = state_q;
    rd_ack      = 1'b0;
    wr_ack      = 1'b0;
    ram_cen_o   = 1'b1;
    ram_wen_o   = 1'b1;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (init_start_i) begin
            state_d = INIT;
          end else if (eng.wr_req_i) begin
            wr_ack      = 1'b1;
            ram_cen_o   = 1'b0;
            ram_wen_o   = 1'b0;
            ram_addr_o  = eng.wr_addr_i;
            ram_wdata_o = eng.wr_data_i;
          end else if (eng.rd_req_i) begin
            rd_ack     = 1'b1;
            ram_cen_o  = 1'b0;
            ram_addr_o = eng.rd_addr_i;
          end
        end
        INIT: begin
          ram_cen_o   = 1'b0;
          ram_wen_o   = 1'b0;
          ram_addr_o  = cnt_q;
          ram_wdata_o = init_data_i;
          if (last_entry) state_d = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Load counter, completion pulse and table-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      init_done_o <= 1'b0;
      ctx_valid_o <= 1'b0;
    end else begin
      init_done_o <= 1'b0;
      if (state_q == IDLE && init_start_i) begin
        cnt_q       <= '0;
        ctx_valid_o <= 1'b0;
      end else if (state_q == INIT) begin
        if (last_entry) begin
          cnt_q       <= '0;
          init_done_o <= 1'b1;
          ctx_valid_o <= 1'b1;
        end else begin
          cnt_q <= cnt_q + ADDR_W'(1);
        end
      end
    end
  end

  // Read strobe one cycle after the grant; keep the last read word afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      rd_valid_q <= rd_ack;
      if (rd_valid_q) rd_hold_q <= ram_rdata_i;
    end
  end

  assign init_addr_o    = cnt_q;
  assign init_busy_o    = (state_q == INIT);
  assign eng.rd_ack_o   = rd_ack;
  assign eng.wr_ack_o   = wr_ack;
  assign eng.rd_valid_o = rd_valid_q;
  assign eng.rd_data_o  = rd_valid_q ? ram_rdata_i : rd_hold_q;

endmodule
